clkdiv_multi: RTL
=================

# clkdiv_multi

Parametrised multi-channel clock divider for the fast PLL output clock. It generalises the fixed divide-by-5 stage into CHANNELS independent dividers, each with a runtime-programmable divisor and 50 % duty for odd divisors. Changing the divisors uses a request/acknowledge handshake and realigns the phases of all channels. It also synchronises the PLL lock and gates all outputs until lock. It sits directly behind the CC_PLL wrapper and feeds pixel/serialiser clock domains.

## Interface
- CHANNELS, 2: number of divided outputs
- DIV_W, 8: divisor width
- DIV_DEFAULT, 5: divisor loaded into every channel at reset
- SYNC_STAGES, 2: lock synchroniser depth (≥2)

- clk_i  in  1  fast clock (PLL CLK0); the only clock
- rst_n_i  in  1  reset; synchronous, active-low
- pll_lock_i  in  1  raw PLL lock, asynchronous to clk_i
- div_i  in  CHANNELS*DIV_W  requested divisors; channel c at [c*DIV_W +: DIV_W]
- div_load_i  in  1  load request, sampled on posedge
- div_busy_o  out  1  a load is pending
- div_ack_o  out  1  one-cycle pulse when the new divisors take effect
- lock_o  out  1  synchronised lock
- clk_o  out  CHANNELS  divided clocks
- phase_o  out  CHANNELS  one-cycle strobe in the cycle before each clk_o rising edge

## Operation
- Reset (rst_n_i=0 at posedge):
  - Every channel divisor = clamp(DIV_DEFAULT); all counters = 0.
  - The synchroniser clears.
  - clk_o, phase_o, lock_o, div_busy_o and div_ack_o are all 0. This includes the negedge stage, which clears on its next negedge.
- clamp(D): a value of 0 or 1 becomes 2. Other values are unchanged.
- Lock:
  - pll_lock_i passes through a SYNC_STAGES flop chain to produce lock_o.
  - While lock_o=0, counters are held at 0 and clk_o and phase_o are 0.
  - Losing lock mid-period drops all outputs on the next cycle.
- Per-channel counter: cnt counts 0..D-1 and wraps to 0.
  - phase_o[c] = 1 when cnt==D-1, or in the first lock_o cycle.
  - Even D: clk_o is high for D/2 clk_i cycles, then low for D/2.
  - Odd D: clk_o is high for D/2 cycles (a half-cycle count), rising on posedge. The extra half cycle comes from a negedge-registered copy ORed with the posedge term.
- Load handshake:
  - When div_load_i=1 and div_busy_o=0, div_i is captured into a shadow register and div_busy_o=1.
  - Requests while busy are ignored; the shadow is not overwritten.
  - The shadow (clamped) is applied in the cycle channel 0 wraps (cnt0==D0-1).
  - In that cycle, every channel counter restarts at 0, which realigns all rising edges.
  - div_ack_o pulses in the same cycle and div_busy_o falls.
  - If lock_o=0 while busy, the shadow is applied in the first lock_o=1 cycle, with ack pulsing then.
  - A simultaneous request and apply cycle: the request is ignored, because busy is still 1 in that cycle.
- Reset during a pending load discards the load; the divisors return to DIV_DEFAULT.

## Timing
- lock_o rises SYNC_STAGES posedges after pll_lock_i is sampled high, and falls after the same delay.
- Counters run from the first cycle with lock_o=1. clk_o is registered, so the first clk_o rising edge is the posedge after lock_o rises (1 cycle latency).
- div_load_i to div_busy_o = 1 cycle.
- Apply happens at the end of the current channel-0 period: at most D0_old cycles after the load.
- The first rising edge at the new divisors occurs on the posedge after div_ack_o.
- The odd-D falling edge occurs on the negedge in the middle of cycle (D-1)/2 of the period.

## Configuration
- CLKDIV_ODD_DUTY_EN defined:
  - The negedge stage is instantiated, giving exactly 50 % duty for odd D.
- CLKDIV_ODD_DUTY_EN undefined:
  - No negedge logic is instantiated; the design is purely posedge.
  - Odd D gives high for (D-1)/2 cycles and low for (D+1)/2 cycles.
  - Even D behaviour is identical in both builds.

## Structure
- Package clkdiv_pkg:
  - the clamp_div function;
  - the DIV_MIN=2 constant;
  - a localparam-style default for SYNC_STAGES.
- Sub-module clkdiv_channel: one counter, the duty logic, the optional negedge stage, and the phase strobe; it is instantiated CHANNELS times.
- The top level owns the lock synchroniser, the shadow register and the handshake.

## Test plan
- Reset behaviour: reset held, then lock asserted at t0 with DIV_DEFAULT=5 → lock_o rises at t0+2, and clk_o[0] rises 1 cycle later. With CLKDIV_ODD_DUTY_EN, high = 2.5 cycles and period = 5.
- Divisor load: load div=4,6 → ack pulses at the channel-0 wrap. Afterwards, ch0 runs 2 high/2 low and ch1 3 high/3 low, and their rising edges coincide every 12 cycles.
- Load while busy: a second load while div_busy_o=1 is ignored → the first divisors are applied and a single ack is issued.
- Clamping: load div=0,1 → both channels divide by 2 (1 high/1 low).
- Lock loss mid-operation: pll_lock_i drops mid-period with a load pending → outputs go to 0 after 2 cycles. After relock, the pending divisors are applied, ack pulses in the first lock_o cycle, and phases are aligned.
- Odd divisor without the macro: D=7 with CLKDIV_ODD_DUTY_EN undefined → 3 cycles high, 4 cycles low.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants and the divisor clamp helper for the multi-channel clock divider.
package clkdiv_pkg;

    localparam logic [31:0] DIV_MIN         = 32'd2;
    localparam int          SYNC_STAGES_DEF = 2;

    // Divisors below DIV_MIN cannot produce a toggling output, so they are raised to DIV_MIN.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: wrap counter, duty term, phase strobe.
// Define CLKDIV_ODD_DUTY_EN to add the negedge stage that gives exact 50 % duty for odd divisors.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             first_i,
    input  logic             restart_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             clk_o,
    output logic             phase_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic [DIV_W-1:0] half_w;
    logic             wrap_w;

    assign half_w = div_i >> 1;
    assign wrap_w = (cnt_q == (div_i - DIV_W'(1)));

    // The first locked cycle behaves like a wrap so the first rising edge follows it.
    always_comb begin
        cnt_d = (wrap_w || first_i || restart_i) ? '0 : cnt_q + DIV_W'(1);
        clk_d = (cnt_d < half_w);
        if (!en_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    assign phase_o = en_i && (wrap_w || first_i);

`ifdef CLKDIV_ODD_DUTY_EN
    logic neg_q;

    // Half-cycle extension of the high phase, only for odd divisors while locked.
    always_ff @(negedge clk_i) begin
        if (!rst_n_i) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= clk_q & div_i[0] & en_i;
        end
    end

    assign clk_o = clk_q | neg_q;
`else
    assign clk_o = clk_q;
`endif

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel clock divider: lock synchroniser, divisor shadow/handshake, CHANNELS dividers.
// Optional exact odd-divisor duty via CLKDIV_ODD_DUTY_EN (see clkdiv_channel).
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 5,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      pll_lock_i,
    input  logic [CHANNELS*DIV_W-1:0] div_i,
    input  logic                      div_load_i,
    output logic                      div_busy_o,
    output logic                      div_ack_o,
    output logic                      lock_o,
    output logic [CHANNELS-1:0]       clk_o,
    output logic [CHANNELS-1:0]       phase_o
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(clamp_div(32'(DIV_DEFAULT)));

    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      lock_prev_q;
    logic                      lock_w, first_w;
    logic                      busy_q, busy_d;
    logic [CHANNELS*DIV_W-1:0] shadow_q;
    logic [CHANNELS*DIV_W-1:0] div_q, div_d;
    logic [CHANNELS-1:0]       phase_w;
    logic                      apply_w;

    assign lock_w  = sync_q[SYNC_STAGES-1];
    assign first_w = lock_w & ~lock_prev_q;
    // Channel 0 strobes on its wrap and on the first locked cycle: both are apply points.
    assign apply_w = busy_q & phase_w[0];

    always_comb begin
        busy_d = busy_q;
        div_d  = div_q;
        if (apply_w) begin
            busy_d = 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                div_d[c*DIV_W +: DIV_W] = DIV_W'(clamp_div(32'(shadow_q[c*DIV_W +: DIV_W])));
            end
        end else if (div_load_i) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q      <= '0;
            lock_prev_q <= 1'b0;
            busy_q      <= 1'b0;
            div_q       <= {CHANNELS{DIV_RST}};
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], pll_lock_i};
            lock_prev_q <= lock_w;
            busy_q      <= busy_d;
            div_q       <= div_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (div_load_i && !busy_q) begin
            shadow_q <= div_i;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        clkdiv_channel #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .en_i     (lock_w),
            .first_i  (first_w),
            .restart_i(apply_w),
            .div_i    (div_q[c*DIV_W +: DIV_W]),
            .clk_o    (clk_o[c]),
            .phase_o  (phase_w[c])
        );
    end

    assign phase_o    = phase_w;
    assign lock_o     = lock_w;
    assign div_busy_o = busy_q;
    assign div_ack_o  = apply_w;

endmodule
